// File: rtl/hazard_scoreboard.sv
// Decode-side scoreboard for long-latency destinations: stalls RAW/WAW/capacity hazards, clears at write-back.
// Optional stall cycle counter output enabled by defining HAZARD_SCOREBOARD_STALLCNT_EN.
module hazard_scoreboard #(
    parameter int NREG            = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            issue_wen,
    input  logic            issue_long,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic            stall,
    output logic [NREG-1:0] busy_vec,
    output logic [3:0]      outstanding,
`ifdef HAZARD_SCOREBOARD_STALLCNT_EN
    output logic [31:0]     stall_cnt,
`endif
    output logic            wb_err
);

    logic [NREG-1:0] r_busy;
    logic [3:0]      r_outstanding;
    logic            r_wb_err;

    logic [31:0]     w_busy_ext;
    logic [31:0]     w_set_ext;
    logic [31:0]     w_clr_ext;
    logic            w_hit1;
    logic            w_hit2;
    logic            w_waw;
    logic            w_full;
    logic            w_stall;
    logic            w_fire;
    logic            w_wb_hit;
    logic            w_wb_spur;

    // Register indices are 5 bits wide; zero-extend so any index is a legal lookup.
    assign w_busy_ext = 32'(r_busy);

    // A write-back landing this cycle is forwarded, so it cancels the hazard on that register.
    assign w_hit1  = w_busy_ext[rs1] && !(wb_valid && (wb_rd == rs1));
    assign w_hit2  = w_busy_ext[rs2] && !(wb_valid && (wb_rd == rs2));
    assign w_waw   = issue_wen && w_busy_ext[issue_rd] && !(wb_valid && (wb_rd == issue_rd));
    assign w_full  = issue_long && issue_wen && (r_outstanding == 4'(MAX_OUTSTANDING)) &&
                     !(wb_valid && w_busy_ext[wb_rd]);
    assign w_stall = issue_valid && (w_hit1 || w_hit2 || w_waw || w_full);

    assign w_fire    = issue_valid && !w_stall && issue_wen && issue_long && (issue_rd != 5'd0);
    assign w_wb_hit  = wb_valid && (wb_rd != 5'd0) && w_busy_ext[wb_rd];
    assign w_wb_spur = wb_valid && (wb_rd != 5'd0) && !w_busy_ext[wb_rd];

    assign w_set_ext = 32'(w_fire) << issue_rd;
    assign w_clr_ext = 32'(w_wb_hit) << wb_rd;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy        <= '0;
            r_outstanding <= '0;
            r_wb_err      <= 1'b0;
        end else begin
            if (flush) begin
                r_busy        <= '0;
                r_outstanding <= '0;
            end else begin
                // Set is applied after clear so a same-rd issue wins over its retiring predecessor.
                r_busy        <= (r_busy & ~w_clr_ext[NREG-1:0]) | w_set_ext[NREG-1:0];
                r_outstanding <= r_outstanding + 4'(w_fire) - 4'(w_wb_hit);
            end
            if (w_wb_spur) begin
                r_wb_err <= 1'b1;
            end
        end
    end

`ifdef HAZARD_SCOREBOARD_STALLCNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + 32'(w_stall);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign stall       = w_stall;
    assign busy_vec    = r_busy;
    assign outstanding = r_outstanding;
    assign wb_err      = r_wb_err;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the EX/MEM/WB forwarding logic.
- Tracks destination registers of in-flight long-latency ops (loads, multi-cycle mul/div). Forwarding cannot cover these ops.
- Raises a decode-stage stall on RAW/WAW hazards against those registers. Clears entries when the result reaches write-back.
- Sits between decode (issue/query) and write-back (retire).

Parameters:
- NREG, 32, number of architectural registers; index 0 is hard-wired zero.
- MAX_OUTSTANDING, 4, maximum long-latency ops in flight; range 1..15.

Ports:
- clk  in  1  core clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- rs1  in  5  decode source register 1.
- rs2  in  5  decode source register 2.
- issue_valid  in  1  decode presents an instruction for issue this cycle.
- issue_rd  in  5  destination register of the issuing instruction.
- issue_wen  in  1  issuing instruction writes rd.
- issue_long  in  1  issuing instruction is long-latency (load/multi-cycle).
- wb_valid  in  1  a long-latency result is written back this cycle.
- wb_rd  in  5  destination of that write-back.
- flush  in  1  pipeline flush; drops all tracked entries.
- stall  out  1  hold decode; combinational.
- busy_vec  out  NREG  current busy bit per register.
- outstanding  out  4  number of tracked in-flight long ops.
- wb_err  out  1  sticky: write-back seen to a non-busy register.

Behaviour:
- Reset (rstn=0, async): busy_vec=0, outstanding=0, wb_err=0; stall then depends only on inputs and evaluates to 0.
- busy[0] is constant 0. Issue or write-back to x0 has no effect on state.
- Hit terms:
  - hit1 = busy[rs1] && !(wb_valid && wb_rd==rs1). Same-cycle write-back is forwarded via the WB path, so it does not stall.
  - hit2 is the same form using rs2.
  - waw = issue_wen && busy[issue_rd] && !(wb_valid && wb_rd==issue_rd).
  - full = issue_long && issue_wen && (outstanding==MAX_OUTSTANDING) && !(wb_valid && busy[wb_rd]).
- stall = issue_valid && (hit1 || hit2 || waw || full). Combinational, zero latency.
- issue_fire = issue_valid && !stall && issue_wen && issue_long && issue_rd!=0.
- Write-back hit: wb_hit = wb_valid && wb_rd!=0 && busy[wb_rd].
- Next state, on the rising edge:
  - wb_hit clears busy[wb_rd].
  - issue_fire sets busy[issue_rd]. Set wins over clear when the same rd sees both in one cycle.
  - outstanding = outstanding + issue_fire - wb_hit. Simultaneous issue and write-back leaves it unchanged. It never exceeds MAX_OUTSTANDING and never underflows.
  - wb_valid && wb_rd!=0 && !busy[wb_rd] sets wb_err. State is otherwise unchanged. wb_err clears only on reset.
- Short-latency writers (issue_long=0) are never tracked; the forwarding unit resolves them.
- flush=1: next state is busy_vec=0, outstanding=0. issue_fire and wb_hit are ignored that cycle. wb_err is kept. stall is still computed from the current state.
- Reset mid-operation: all in-flight tracking is lost immediately. Upstream pipeline reset is asserted concurrently.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_STALLCNT_EN.
- When defined:
  - Adds output stall_cnt [31:0]. It increments each cycle stall=1 and wraps at 2^32-1→0.
  - Resets to 0 on rstn. It is not cleared by flush.
- When undefined:
  - Port is absent; no counter logic.
  - All other behaviour is identical.

Test Plan:
- Load-use: issue lw x5 (long) → busy[5]=1, outstanding=1; next cycle rs1=5, issue_valid=1 → stall=1. Assert wb_valid, wb_rd=5 → stall=0 that same cycle; busy[5]=0 next edge.
- Full: issue long ops to x1..x4 → outstanding=4. Long issue to x6 → stall=1. Same cycle wb_rd=2 → stall=0; x6 accepted; outstanding stays 4.
- Same-rd collision: busy[7]=1, issue long to x7 with wb_rd=7 in one cycle → no stall; busy[7]=1 next edge; outstanding unchanged.
- x0 and short ops: issue long to x0 and short op to x9 → busy_vec=0, outstanding=0, stall=0 for rs1=0/rs2=9.
- Flush and spurious write-back: busy[3]=busy[8]=1, flush=1 → busy_vec=0, outstanding=0. Then wb_valid, wb_rd=3 → wb_err=1 and stays 1 until rstn.
- Counter (with HAZARD_SCOREBOARD_STALLCNT_EN defined): hold the stalling condition 5 cycles → stall_cnt=5. Async rstn pulse mid-cycle → all outputs 0 immediately.
